// File: rtl/dual_port_memory.sv
// dual_port_memory: single-clock RAM with read/write data port, read-only instruction port, zero-fill after reset
//   clk, rst                       clock, synchronous active-high reset
//   d_read/d_write/d_push          data-port capture, write, latch-to-output transfer
//   d_addr, d_wdata, d_rdata       data-port address, write data, registered read data
//   d_valid                        one-cycle pulse when d_rdata is updated
//   i_read/i_push, i_addr, i_rdata instruction-port equivalents (read-only)
//   i_valid                        one-cycle pulse when i_rdata is updated
//   ready                          requests are accepted
//   err                            sticky out-of-range access flag, cleared only by rst
module dual_port_memory #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic              d_push,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  input  logic              i_read,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              ready,
  output logic              err
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0]        state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] d_lat, i_lat, d_mem, i_mem;
  logic              d_in, i_in, run;
  // extra top bit keeps the compare exact when DEPTH == 2**ADDR_W
  assign d_in  = {1'b0, d_addr} < (ADDR_W+1)'(DEPTH);
  assign i_in  = {1'b0, i_addr} < (ADDR_W+1)'(DEPTH);
  assign d_mem = d_in ? mem[d_addr[IDX_W-1:0]] : '0;
  assign i_mem = i_in ? mem[i_addr[IDX_W-1:0]] : '0;
  assign run   = !rst && state == READY;
  assign ready = run;
  // memory kept out of the reset branch so contents survive rst when INIT_CLEAR=0
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[cnt] <= '0;
    else if (run && d_write && d_in) mem[d_addr[IDX_W-1:0]] <= d_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT_CLEAR != 0 ? CLEAR : READY;
      cnt     <= '0;
      d_lat   <= '0;
      i_lat   <= '0;
      d_rdata <= '0;
      i_rdata <= '0;
      d_valid <= 1'b0;
      i_valid <= 1'b0;
      err     <= 1'b0;
    end else if (state == CLEAR) begin
      cnt     <= cnt + 1'b1;
      state   <= cnt == IDX_W'(DEPTH - 1) ? READY : CLEAR;
      d_valid <= 1'b0;
      i_valid <= 1'b0;
    end else begin
      if (d_read) d_lat <= d_mem;
      if (i_read) i_lat <= i_mem;
      // a push alongside a read forwards the fresh word straight to the output
      if (d_push) d_rdata <= d_read ? d_mem : d_lat;
      if (i_push) i_rdata <= i_read ? i_mem : i_lat;
      d_valid <= d_push;
      i_valid <= i_push;
      if (((d_read || d_write) && !d_in) || (i_read && !i_in)) err <= 1'b1;
    end
  end
endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits for both ports.
REQ-002 Parameter ADDR_W, default 16: address width for both ports.
REQ-003 Parameter DEPTH, default 256: implemented words, 1..2^ADDR_W.
REQ-004 Parameter INIT_CLEAR, default 1: 1 = zero all words after reset; 0 = retain contents.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 d_read  in  1  data-port read: capture mem[d_addr] into data latch.
REQ-008 d_write  in  1  data-port write of d_wdata to mem[d_addr].
REQ-009 d_push  in  1  data-port push: transfer data latch to d_rdata.
REQ-010 d_addr  in  ADDR_W  data-port address.
REQ-011 d_wdata  in  DATA_W  data-port write data.
REQ-012 d_rdata  out  DATA_W  data-port registered output.
REQ-013 d_valid  out  1  one-cycle pulse: d_rdata updated by a push.
REQ-014 i_read  in  1  instruction-port read into instruction latch (read-only port).
REQ-015 i_push  in  1  instruction-port push: latch to i_rdata.
REQ-016 i_addr  in  ADDR_W  instruction-port address.
REQ-017 i_rdata  out  DATA_W  instruction-port registered output.
REQ-018 i_valid  out  1  one-cycle pulse: i_rdata updated by a push.
REQ-019 ready  out  1  high when requests are accepted (READY state).
REQ-020 err  out  1  sticky: an accepted request used address >= DEPTH.

Function
REQ-021 FSM states CLEAR and READY; rst forces CLEAR if INIT_CLEAR=1, else READY.
REQ-022 CLEAR: clear counter starts at 0, writes 0 to mem[counter] each cycle, increments; after writing DEPTH-1 moves to READY next edge (ready high exactly DEPTH cycles after rst deasserts).
REQ-023 In CLEAR all d_/i_ requests ignored; latches, outputs, err unchanged.
REQ-024 READY: d_read at edge N sets data latch = mem[d_addr]; latency 1.
REQ-025 d_push at edge N sets d_rdata = data latch, d_valid = 1 for cycle after N only.
REQ-026 d_read and d_push same cycle: d_rdata and latch both take mem[d_addr] (forwarding).
REQ-027 d_write at edge N updates mem[d_addr]; visible to reads from cycle N+1.
REQ-028 d_read and d_write same cycle, same address: read returns pre-write contents.
REQ-029 i_read / i_push behave as REQ-024..026 with i_ signals; ports fully independent, both may act same cycle.
REQ-030 i_read same cycle as d_write to same address: i latch gets pre-write contents.
REQ-031 Address >= DEPTH: write dropped, read captures 0, err set; err cleared only by rst.
REQ-032 Push with no prior read: transfers current latch value (0 after reset).
REQ-033 Latches and output registers hold value until next read/push; no auto-clear.

Reset
REQ-034 On rst: d_rdata=0, i_rdata=0, both latches=0, d_valid=0, i_valid=0, err=0, ready=0 during rst cycle.
REQ-035 rst mid-CLEAR restarts clear counter at 0; rst in READY with INIT_CLEAR=0 keeps memory contents.
REQ-036 Requests asserted while rst high are ignored.

Verification (DATA_W=16, ADDR_W=16, DEPTH=256, INIT_CLEAR=1)
REQ-037 Release rst; count cycles -> ready rises exactly 256 cycles later; d_read addr 200 then d_push -> d_rdata=0.
REQ-038 d_write addr 3 data 47; next cycle d_read addr 3; next d_push -> d_rdata=47, d_valid high one cycle.
REQ-039 d_read+d_push same cycle addr 3 (holding 47) -> d_rdata=47 one edge later; i_read+i_push addr 3 same cycle -> i_rdata=47 simultaneously.
REQ-040 mem[5]=10; d_write addr 5 data 99 with d_read addr 5 and i_read addr 5 same cycle -> both latches 10; following reads return 99.
REQ-041 d_write addr 300 data 7 -> err=1, mem unchanged; d_read addr 300 + push -> d_rdata=0; err stays 1 until rst.
REQ-042 rst pulsed 100 cycles into CLEAR -> ready rises 256 cycles after second release; all outputs 0.
